uart_rx_word: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_word_if.sv | 31 +++
 rtl/uart_rx_byte.sv | 129 ++++++++++++
 rtl/uart_rx_word.sv | 102 ++++++++++
 tb/tb_uart_rx_word.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both ends of the link (uart_tx / uart_rx_word).
// Baud default, frame size and the common FSM state encoding live here so the
// transmitter and receiver cannot drift apart.
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    // 8N1 framing: eight data bits, LSB first
    localparam int DATA_BITS = 8;

    // Line-level FSM states; BREAK is receive-only (line held low after a bad stop bit)
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_word_if.sv
// Receive-side bus from uart_rx_word toward the processing logic.
//
// Valid semantics: o_byte_valid, o_word_valid and o_frame_err are single-cycle
// pulses with no back-pressure (there is no ready). o_byte / o_word are stable
// from their pulse until the next pulse of the same kind, so a consumer may
// sample them either on the pulse or at any later time. o_word_valid only ever
// rises in the same cycle as o_byte_valid. o_active and o_state are levels.
interface uart_rx_word_if #(
    parameter int WORD_W = 32
);
    import uart_pkg::*;

    logic [DATA_BITS-1:0] o_byte;
    logic                 o_byte_valid;
    logic [WORD_W-1:0]    o_word;
    logic                 o_word_valid;
    logic                 o_active;
    logic                 o_frame_err;
    uart_state_t          o_state;

    modport master (
        output o_byte, o_byte_valid, o_word, o_word_valid,
               o_active, o_frame_err, o_state
    );

    modport slave (
        input  o_byte, o_byte_valid, o_word, o_word_valid,
               o_active, o_frame_err, o_state
    );

endinterface

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: 2-flop synchronizer, line FSM and LSB-first shift
// register. o_valid / o_frame_err are combinational strobes raised in the last
// STOP cycle; the parent registers them, giving one cycle of output latency.
// CLKS_PER_BIT must be >= 4.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_active,
    output uart_state_t          o_state
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_load;
    logic                 w_cnt_zero;
    logic                 w_reload;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;

    assign w_cnt_zero = (r_cnt == '0);

    // Synchronize the asynchronous line; flops idle high so reset looks like an idle line
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= serial_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; disabling the receiver overrides everything and returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!r_rx_s) w_state_next = START;
            START:   if (w_cnt_zero) w_state_next = r_rx_s ? IDLE : DATA;
            DATA:    if (w_cnt_zero && (r_bit_idx == IDX_LAST)) w_state_next = STOP;
            STOP:    if (w_cnt_zero) w_state_next = r_rx_s ? IDLE : BREAK;
            BREAK:   if (r_rx_s) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (!enable) begin
            w_state_next = IDLE;
        end
    end

    // FSM outputs: activity level and the stop-bit verdict strobes
    always_comb begin
        o_active    = 1'b0;
        o_valid     = 1'b0;
        o_frame_err = 1'b0;
        case (r_state)
            START, DATA: o_active = 1'b1;
            STOP: begin
                o_active = 1'b1;
                if (w_cnt_zero && enable) begin
                    o_valid     = r_rx_s;
                    o_frame_err = !r_rx_s;
                end
            end
            default: ;
        endcase
    end

    // Counter reload value for the state being entered (half bit in START lands on mid-bit)
    always_comb begin
        case (w_state_next)
            START:      w_cnt_load = CNT_HALF;
            DATA, STOP: w_cnt_load = CNT_FULL;
            default:    w_cnt_load = '0;
        endcase
    end

    // Reload on every state change and on each new data bit, so the counter never wraps
    assign w_reload = (w_state_next != r_state) || ((r_state == DATA) && w_cnt_zero);

    // Bit timer, bit index and LSB-first shift register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_reload) begin
                r_cnt <= w_cnt_load;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == START) begin
                r_bit_idx <= '0;
            end else if ((r_state == DATA) && w_cnt_zero) begin
                r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    assign o_byte  = r_shift;
    assign o_state = r_state;

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver with word packing. Good bytes are registered out as one-cycle
// pulses and packed little-endian (first byte in [7:0]) into WORD_W-bit words.
// WORD_W must equal 8*BYTES_PER_WORD. A framing error or enable=0 restarts
// word assembly from byte 0.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT,
    parameter int BYTES_PER_WORD = 4,
    parameter int WORD_W         = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           serial_in,
    uart_rx_word_if.master rx_if
);
    localparam int WIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(BYTES_PER_WORD - 1);

    logic [DATA_BITS-1:0] w_byte;
    logic                 w_valid;
    logic                 w_frame_err;
    logic                 w_active;
    uart_state_t          w_state;

    logic [WIDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]    r_acc;
    logic [WORD_W-1:0]    w_acc_next;
    logic [WORD_W-1:0]    r_word;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_byte_valid;
    logic                 r_word_valid;
    logic                 r_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .serial_in   (serial_in),
        .o_byte      (w_byte),
        .o_valid     (w_valid),
        .o_frame_err (w_frame_err),
        .o_active    (w_active),
        .o_state     (w_state)
    );

    // Drop the incoming byte into its little-endian slot of the assembling word
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (r_idx == WIDX_W'(i)) begin
                w_acc_next[i*DATA_BITS +: DATA_BITS] = w_byte;
            end
        end
    end

    // Output registers and word assembly; the completing byte and its word share one cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (!enable) begin
                r_idx <= '0;
            end else if (w_frame_err) begin
                r_frame_err <= 1'b1;
                r_idx       <= '0;
            end else if (w_valid) begin
                r_byte       <= w_byte;
                r_byte_valid <= 1'b1;
                r_acc        <= w_acc_next;
                if (r_idx == WIDX_LAST) begin
                    r_word       <= w_acc_next;
                    r_word_valid <= 1'b1;
                    r_idx        <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign rx_if.o_byte       = r_byte;
    assign rx_if.o_byte_valid = r_byte_valid;
    assign rx_if.o_word       = r_word;
    assign rx_if.o_word_valid = r_word_valid;
    assign rx_if.o_frame_err  = r_frame_err;
    assign rx_if.o_active     = w_active;
    assign rx_if.o_state      = w_state;

endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word at 16 clocks per bit. Directed frames
// push their hand-computed bytes/words into expected queues; a negedge monitor
// pops and compares whenever a valid pulse appears.
module tb_uart_rx_word;
    import uart_pkg::*;

    localparam int C   = 16;
    localparam int BPW = 4;
    localparam int WW  = 32;

    logic clock = 1'b0;
    logic reset_n;
    logic enable;
    logic serial_in;

    uart_rx_word_if #(.WORD_W(WW)) rx_if ();

    uart_rx_word #(
        .CLKS_PER_BIT   (C),
        .BYTES_PER_WORD (BPW),
        .WORD_W         (WW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .serial_in (serial_in),
        .rx_if     (rx_if)
    );

    // Clock
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int active_cycles = 0;
    int ferr_seen = 0;
    int a0;
    int a1;
    int f0;
    logic [7:0]    v;
    logic [7:0]    exp_byte_q[$];
    logic [WW-1:0] exp_word_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic note_unexpected(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL unexpected_%s: got pulse with 0x%0h, expected no pulse", name, act);
    endtask

    // Advance n clocks; inputs change 1 time unit after the rising edge
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2);
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        wait_clk(C);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            wait_clk(C);
        end
        serial_in = stop_bit;
        wait_clk(C);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_byte_q.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_bytes_missing"}, exp_byte_q.size(), 0);
        check({name, "_words_missing"}, exp_word_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_byte"},       rx_if.o_byte, 0);
        check({name, "_word"},       rx_if.o_word, 0);
        check({name, "_byte_valid"}, rx_if.o_byte_valid, 0);
        check({name, "_word_valid"}, rx_if.o_word_valid, 0);
        check({name, "_frame_err"},  rx_if.o_frame_err, 0);
        check({name, "_active"},     rx_if.o_active, 0);
        check({name, "_state"},      rx_if.o_state, IDLE);
    endtask

    // Monitor / scoreboard: compare every output pulse against the expected queues
    always @(negedge clock) begin
        if (rx_if.o_active) active_cycles = active_cycles + 1;
        if (rx_if.o_byte_valid) begin
            if (exp_byte_q.size() == 0) note_unexpected("byte", rx_if.o_byte);
            else check("byte", rx_if.o_byte, exp_byte_q.pop_front());
        end
        if (rx_if.o_word_valid) begin
            check("word_with_byte_valid", rx_if.o_byte_valid, 1'b1);
            if (exp_word_q.size() == 0) note_unexpected("word", rx_if.o_word);
            else check("word", rx_if.o_word, exp_word_q.pop_front());
        end
        if (rx_if.o_frame_err) begin
            ferr_seen = ferr_seen + 1;
            check("frame_err_no_byte_valid", rx_if.o_byte_valid, 1'b0);
        end
    end

    // Stimulus
    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        serial_in = 1'b1;
        wait_clk(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        wait_clk(C);

        // Single good frame: one byte pulse, no word, active only for the frame
        check("idle_active", rx_if.o_active, 1'b0);
        a0 = active_cycles;
        send_good(8'h9B);
        wait_clk(C);
        a1 = active_cycles - a0;
        check("frame_active_len_in_range", (a1 >= 9*C) && (a1 <= 10*C), 1'b1);
        check("active_after_frame", rx_if.o_active, 1'b0);
        check("byte_hold", rx_if.o_byte, 8'h9B);
        check("word_untouched", rx_if.o_word, 0);
        check_drained("single");

        // Restart word assembly, then four back-to-back frames form one word
        do_reset();
        exp_word_q.push_back(32'h041AF39B);
        send_good(8'h9B);
        send_good(8'hF3);
        send_good(8'h1A);
        send_good(8'h04);
        wait_clk(C);
        check_drained("b2b");
        check("b2b_word_hold", rx_if.o_word, 32'h041AF39B);

        // Five-cycle low glitch: START briefly, back to IDLE, no pulses
        a0 = active_cycles;
        serial_in = 1'b0;
        wait_clk(5);
        serial_in = 1'b1;
        wait_clk(2*C);
        a1 = active_cycles - a0;
        check("glitch_active_len_in_range", (a1 >= 1) && (a1 <= C), 1'b1);
        check("glitch_state", rx_if.o_state, IDLE);
        check_drained("glitch");

        // One good byte, then a bad stop bit with the line held low
        f0 = ferr_seen;
        send_good(8'h77);
        send_byte(8'h55, 1'b0);
        a0 = active_cycles;
        wait_clk(20);
        check("break_state", rx_if.o_state, BREAK);
        wait_clk(20);
        a1 = active_cycles - a0;
        check("break_active_cycles", a1, 0);
        check("frame_err_count", ferr_seen - f0, 1);
        check("break_byte_hold", rx_if.o_byte, 8'h77);
        serial_in = 1'b1;
        wait_clk(C);
        check("break_exit_state", rx_if.o_state, IDLE);
        exp_word_q.push_back(32'hD4C3B2A1);
        send_good(8'hA1);
        send_good(8'hB2);
        send_good(8'hC3);
        send_good(8'hD4);
        wait_clk(C);
        check_drained("ferr");

        // Two bytes, a one-cycle enable drop, then four bytes form a fresh word
        send_good(8'hE1);
        send_good(8'hE2);
        wait_clk(4);
        enable = 1'b0;
        wait_clk(1);
        enable = 1'b1;
        wait_clk(4);
        check("disable_byte_hold", rx_if.o_byte, 8'hE2);
        check("disable_word_hold", rx_if.o_word, 32'hD4C3B2A1);
        exp_word_q.push_back(32'h04030201);
        send_good(8'h01);
        send_good(8'h02);
        send_good(8'h03);
        send_good(8'h04);
        wait_clk(C);
        check_drained("enable");
        check("enable_word_hold", rx_if.o_word, 32'h04030201);

        // Reset in the middle of data bit 3, then a full word is received cleanly
        v = 8'h9B;
        serial_in = 1'b0;
        wait_clk(C);
        for (int i = 0; i < 3; i++) begin
            serial_in = v[i];
            wait_clk(C);
        end
        serial_in = v[3];
        wait_clk(C/2);
        check("mid_frame_state", rx_if.o_state, DATA);
        check("mid_frame_active", rx_if.o_active, 1'b1);
        reset_n   = 1'b0;
        serial_in = 1'b1;
        wait_clk(1);
        check_reset_outputs("midreset");
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2*C);
        exp_word_q.push_back(32'h817E3CA5);
        send_good(8'hA5);
        send_good(8'h3C);
        send_good(8'h7E);
        send_good(8'h81);
        wait_clk(C);
        check_drained("after_reset");
        check("after_reset_byte", rx_if.o_byte, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
